// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states, program entry type and guard result shared by the sequencer
package alu_seq_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;
    localparam logic [7:0] GUARD_RES = 8'hFF;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_EMIT} state_t;
    typedef struct packed {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } entry_t;
endpackage

// File: rtl/alu_seq_prog_mem.sv
// alu_seq_prog_mem: DEPTH-entry program store, one synchronous write port, one combinational read port
module alu_seq_prog_mem
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [IW-1:0] i_waddr,
    input  entry_t        i_wdata,
    input  logic [IW-1:0] i_raddr,
    output entry_t        o_rdata
);
    entry_t r_mem [DEPTH];
    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: buffers {op,a,b} entries, issues them to the ALU executor, emits results (SEQ_DIV_GUARD_EN: short-circuit divide-by-zero)
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [1:0]    load_op,
    input  logic [3:0]    load_a,
    input  logic [3:0]    load_b,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [1:0]    exec_instruction,
    output logic [3:0]    exec_a,
    output logic [3:0]    exec_b,
    input  logic [7:0]    exec_result,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [7:0]    res_data,
    output logic [IW-1:0] res_index,
    output logic          res_err
);
    state_t        r_state, w_next;
    logic [IW:0]   r_count, r_len;
    logic [IW-1:0] r_ptr, w_raddr;
    entry_t        r_exec, w_rdata, w_wdata, w_entry;
    logic [7:0]    r_res_data;
    logic [IW-1:0] r_res_index;
    logic          r_res_err, r_done;
    logic          w_load, w_go, w_accept, w_last, w_advance, w_fetch, w_guard;

    assign w_wdata    = {load_op, load_a, load_b};
    assign load_ready = (r_state == S_IDLE) && (r_count < (IW+1)'(DEPTH));
    assign w_load     = load_valid && load_ready;
    assign w_go       = (r_state == S_IDLE) && start && ((r_count != '0) || w_load);
    assign w_accept   = (r_state == S_EMIT) && res_ready;
    assign w_last     = {1'b0, r_ptr} == r_len - 1'b1;
    assign w_advance  = w_accept && !w_last;
    assign w_fetch    = w_go || w_advance;
    assign w_raddr    = (r_state == S_EMIT) ? r_ptr + 1'b1 : '0;
    // a load landing on the start edge may be entry 0 itself
    assign w_entry    = (w_load && r_count[IW-1:0] == w_raddr) ? w_wdata : w_rdata;
`ifdef SEQ_DIV_GUARD_EN
    assign w_guard    = (w_entry.op == OP_DIV) && (w_entry.b == 4'd0);
`else
    assign w_guard    = 1'b0;
`endif

    alu_seq_prog_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .i_we    (w_load),
        .i_waddr (r_count[IW-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk)
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;

    always_comb begin
        w_next = r_state;
        w_next = (r_state == S_IDLE)    ? (w_go ? (w_guard ? S_EMIT : S_ISSUE) : S_IDLE)
               : (r_state == S_ISSUE)   ? S_CAPTURE
               : (r_state == S_CAPTURE) ? S_EMIT
               : !w_accept              ? S_EMIT
               : w_last                 ? S_IDLE
               : w_guard                ? S_EMIT : S_ISSUE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_len       <= '0;
            r_ptr       <= '0;
            r_exec      <= '0;
            r_res_data  <= '0;
            r_res_index <= '0;
            r_res_err   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done  <= w_accept && w_last;
            r_count <= (w_accept && w_last) ? '0 : r_count + (IW+1)'(w_load);
            if (w_go) begin
                r_ptr <= '0;
                r_len <= r_count + (IW+1)'(w_load);
            end else if (w_advance) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if (w_fetch && !w_guard) r_exec <= w_entry;
            if (w_fetch && w_guard) begin
                r_res_data  <= GUARD_RES;
                r_res_index <= w_raddr;
                r_res_err   <= 1'b1;
            end else if (r_state == S_CAPTURE) begin
                r_res_data  <= exec_result;
                r_res_index <= r_ptr;
                r_res_err   <= 1'b0;
            end
        end
    end

    assign busy             = r_state != S_IDLE;
    assign res_valid        = r_state == S_EMIT;
    assign done             = r_done;
    assign exec_instruction = r_exec.op;
    assign exec_a           = r_exec.a;
    assign exec_b           = r_exec.b;
    assign res_data         = r_res_data;
    assign res_index        = r_res_index;
    assign res_err          = r_res_err;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed checks of alu_op_sequencer against a behavioural registered ALU executor
module tb_alu_op_sequencer;
    logic       clk = 1'b0;
    logic       rst, load_valid, load_ready, start, busy, done;
    logic [1:0] load_op, exec_instruction;
    logic [3:0] load_a, load_b, exec_a, exec_b;
    logic [7:0] exec_result, res_data;
    logic       res_valid, res_ready, res_err;
    logic [2:0] res_index;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_op(load_op), .load_a(load_a), .load_b(load_b), .start(start),
        .busy(busy), .done(done), .exec_instruction(exec_instruction),
        .exec_a(exec_a), .exec_b(exec_b), .exec_result(exec_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_index(res_index), .res_err(res_err)
    );

    // registered executor: add/sub/mul/div, divide by zero yields 0
    always_ff @(posedge clk)
        if (rst) exec_result <= 8'h00;
        else case (exec_instruction)
            2'b00:   exec_result <= {4'h0, exec_a} + {4'h0, exec_b};
            2'b01:   exec_result <= {4'h0, exec_a} - {4'h0, exec_b};
            2'b10:   exec_result <= {4'h0, exec_a} * {4'h0, exec_b};
            default: exec_result <= (exec_b == 4'd0) ? 8'h00 : {4'h0, exec_a} / {4'h0, exec_b};
        endcase

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_entry(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        load_valid = 1'b1;
        load_op = op;
        load_a = a;
        load_b = b;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic wait_result(input int lat, input logic [7:0] d, input logic [2:0] idx, input logic err);
        int n = 0;
        do begin
            tick();
            start = 1'b0;
            load_valid = 1'b0;
            n++;
        end while (!res_valid && n < 12);
        check($sformatf("latency idx%0d", idx), n, lat);
        check($sformatf("res_valid idx%0d", idx), res_valid, 1);
        check($sformatf("res_data idx%0d", idx), res_data, d);
        check($sformatf("res_index idx%0d", idx), res_index, idx);
        check($sformatf("res_err idx%0d", idx), res_err, err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load_valid = 1'b0; load_op = 2'b00; load_a = 4'd0; load_b = 4'd0;
        start = 1'b0; res_ready = 1'b0;
        tick(); tick();
        check("rst busy", busy, 0);
        check("rst load_ready", load_ready, 1);
        check("rst res_valid", res_valid, 0);
        check("rst done", done, 0);
        check("rst exec", {exec_instruction, exec_a, exec_b}, 0);
        check("rst res", {res_data, res_index, res_err}, 0);
        rst = 1'b0;

        // basic four-op program, res_ready held high
        res_ready = 1'b1;
        load_entry(2'b00, 4'd10, 4'd5);
        load_entry(2'b01, 4'd10, 4'd5);
        load_entry(2'b10, 4'd10, 4'd5);
        load_entry(2'b11, 4'd10, 4'd5);
        start = 1'b1;
        wait_result(3, 8'd15, 3'd0, 1'b0);
        wait_result(3, 8'd5, 3'd1, 1'b0);
        wait_result(3, 8'd50, 3'd2, 1'b0);
        wait_result(3, 8'd2, 3'd3, 1'b0);
        tick();
        check("t1 done", done, 1);
        check("t1 busy", busy, 0);
        check("t1 load_ready", load_ready, 1);
        check("t1 res_valid", res_valid, 0);
        tick();
        check("t1 done single", done, 0);

        // backpressure at index 1
        load_entry(2'b00, 4'd10, 4'd5);
        load_entry(2'b01, 4'd10, 4'd5);
        load_entry(2'b10, 4'd10, 4'd5);
        load_entry(2'b11, 4'd10, 4'd5);
        start = 1'b1;
        wait_result(3, 8'd15, 3'd0, 1'b0);
        tick();
        res_ready = 1'b0;
        wait_result(2, 8'd5, 3'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2 hold valid", res_valid, 1);
            check("t2 hold data", {res_data, res_index}, {8'd5, 3'd1});
            check("t2 hold exec", {exec_instruction, exec_a, exec_b}, {2'b01, 4'd10, 4'd5});
        end
        res_ready = 1'b1;
        wait_result(3, 8'd50, 3'd2, 1'b0);
        wait_result(3, 8'd2, 3'd3, 1'b0);
        tick();
        check("t2 done", done, 1);

        // overfill: ninth entry refused
        for (int i = 0; i < 8; i++) begin
            check("t3 load_ready", load_ready, 1);
            load_entry(2'b00, 4'(i), 4'd1);
        end
        check("t3 full", load_ready, 0);
        load_valid = 1'b1; load_op = 2'b00; load_a = 4'd15; load_b = 4'd15;
        tick();
        load_valid = 1'b0;
        check("t3 still full", load_ready, 0);
        start = 1'b1;
        for (int i = 0; i < 8; i++) wait_result(3, 8'(i + 1), 3'(i), 1'b0);
        tick();
        check("t3 done", done, 1);
        check("t3 no ninth", res_valid, 0);

        // negative result passthrough, load on start edge joins the run
        load_entry(2'b01, 4'd3, 4'd5);
        load_valid = 1'b1; load_op = 2'b00; load_a = 4'd1; load_b = 4'd2; start = 1'b1;
        wait_result(3, 8'hFE, 3'd0, 1'b0);
        wait_result(3, 8'd3, 3'd1, 1'b0);
        tick();
        check("t4 done", done, 1);

        // empty program, load and start together
        load_valid = 1'b1; load_op = 2'b00; load_a = 4'd2; load_b = 4'd3; start = 1'b1;
        wait_result(3, 8'd5, 3'd0, 1'b0);
        tick();
        check("t4b done", done, 1);

        // divide by zero
        load_entry(2'b11, 4'd7, 4'd0);
        start = 1'b1;
`ifdef SEQ_DIV_GUARD_EN
        wait_result(1, 8'hFF, 3'd0, 1'b1);
        check("t5 exec kept", {exec_instruction, exec_a, exec_b}, {2'b00, 4'd2, 4'd3});
`else
        wait_result(3, 8'h00, 3'd0, 1'b0);
        check("t5 exec issued", {exec_instruction, exec_a, exec_b}, {2'b11, 4'd7, 4'd0});
`endif
        tick();
        check("t5 done", done, 1);

        // reset mid-run during EMIT of index 2
        load_entry(2'b00, 4'd1, 4'd1);
        load_entry(2'b00, 4'd2, 4'd2);
        load_entry(2'b00, 4'd3, 4'd3);
        load_entry(2'b00, 4'd4, 4'd4);
        start = 1'b1;
        wait_result(3, 8'd2, 3'd0, 1'b0);
        wait_result(3, 8'd4, 3'd1, 1'b0);
        wait_result(3, 8'd6, 3'd2, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6 busy", busy, 0);
        check("t6 res_valid", res_valid, 0);
        check("t6 load_ready", load_ready, 1);
        check("t6 done", done, 0);
        check("t6 res_data", res_data, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6 start ignored", busy, 0);
        tick();
        check("t6 no done", done, 0);
        check("t6 idle", {busy, res_valid}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
